// File: rtl/frv_pipeline_memory.sv
// ============================================================================
// frv_pipeline_memory : pipeline stage 4, retires results, waits on data memory
// Revision: 1.0
// ============================================================================
`default_nettype none

module frv_pipeline_memory #(
   parameter int XLEN = 32
) (
   input  logic            g_clk,
   input  logic            g_resetn,
   input  logic [4:0]      s4_rd,
   input  logic [XLEN-1:0] s4_opr_a,
   input  logic [XLEN-1:0] s4_opr_b,
   input  logic [31:0]     s4_pc,
   input  logic [4:0]      s4_uop,
   input  logic [4:0]      s4_fu,
   input  logic            s4_trap,
   input  logic            s4_p_valid,
   output logic            s4_p_busy,
   input  logic            flush,
   input  logic            dmem_rsp_valid,
   input  logic            dmem_rsp_error,
   input  logic [31:0]     dmem_rsp_rdata,
   output logic            wb_valid,
   output logic            wb_wen,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] wb_wdata,
   output logic [31:0]     wb_pc,
   output logic            trap_valid,
   output logic [5:0]      trap_cause,
   output logic [31:0]     trap_pc
);

   localparam logic [0:0] ST_EMPTY    = 1'b0;
   localparam logic [0:0] ST_MEM_WAIT = 1'b1;

   logic [0:0]      state, state_nxt;
   logic            drop, drop_nxt;
   logic [4:0]      mem_rd, mem_rd_nxt;
   logic [31:0]     mem_pc, mem_pc_nxt;
   logic [4:0]      mem_uop, mem_uop_nxt;
   logic [1:0]      mem_off, mem_off_nxt;

   logic            wb_valid_nxt, wb_wen_nxt;
   logic [4:0]      wb_rd_nxt;
   logic [XLEN-1:0] wb_wdata_nxt;
   logic [31:0]     wb_pc_nxt;
   logic            trap_valid_nxt;
   logic [5:0]      trap_cause_nxt;
   logic [31:0]     trap_pc_nxt;

   logic            accept;
   logic [7:0]      byte_sel;
   logic [15:0]     half_sel;
   logic [31:0]     fmt32;
   logic            ext_bit;
   logic [XLEN-1:0] load_data;

   // Load alignment: byte lane by offset, half lane by offset[1] only.
   always_comb begin
      byte_sel = dmem_rsp_rdata[{mem_off, 3'b000} +: 8];
      half_sel = mem_off[1] ? dmem_rsp_rdata[31:16] : dmem_rsp_rdata[15:0];
      case (mem_uop[2:1])
         2'b00:   fmt32 = {{24{mem_uop[0] & byte_sel[7]}}, byte_sel};
         2'b01:   fmt32 = {{16{mem_uop[0] & half_sel[15]}}, half_sel};
         default: fmt32 = dmem_rsp_rdata;
      endcase
      ext_bit = mem_uop[0] & fmt32[31];
   end

   generate
      if (XLEN > 32) begin : g_wide
         assign load_data = {{(XLEN-32){ext_bit}}, fmt32};
      end else begin : g_narrow
         assign load_data = fmt32[XLEN-1:0];
      end
   endgenerate

   logic unused_ok;
   assign unused_ok = ^{ext_bit, s4_opr_b[XLEN-1:2], s4_fu[4:3], s4_fu[1:0], mem_uop[3]};

   assign accept = s4_p_valid && !s4_p_busy && !flush;

   // State and output register process
   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         state      <= ST_EMPTY;
         drop       <= 1'b0;
         mem_rd     <= '0;
         mem_pc     <= '0;
         mem_uop    <= '0;
         mem_off    <= '0;
         wb_valid   <= 1'b0;
         wb_wen     <= 1'b0;
         wb_rd      <= '0;
         wb_wdata   <= '0;
         wb_pc      <= '0;
         trap_valid <= 1'b0;
         trap_cause <= '0;
         trap_pc    <= '0;
      end else begin
         state      <= state_nxt;
         drop       <= drop_nxt;
         mem_rd     <= mem_rd_nxt;
         mem_pc     <= mem_pc_nxt;
         mem_uop    <= mem_uop_nxt;
         mem_off    <= mem_off_nxt;
         wb_valid   <= wb_valid_nxt;
         wb_wen     <= wb_wen_nxt;
         wb_rd      <= wb_rd_nxt;
         wb_wdata   <= wb_wdata_nxt;
         wb_pc      <= wb_pc_nxt;
         trap_valid <= trap_valid_nxt;
         trap_cause <= trap_cause_nxt;
         trap_pc    <= trap_pc_nxt;
      end
   end

   // Next-state process; pulses default low, payload fields hold
   always_comb begin
      state_nxt      = state;
      drop_nxt       = drop;
      mem_rd_nxt     = mem_rd;
      mem_pc_nxt     = mem_pc;
      mem_uop_nxt    = mem_uop;
      mem_off_nxt    = mem_off;
      wb_valid_nxt   = 1'b0;
      wb_wen_nxt     = 1'b0;
      wb_rd_nxt      = wb_rd;
      wb_wdata_nxt   = wb_wdata;
      wb_pc_nxt      = wb_pc;
      trap_valid_nxt = 1'b0;
      trap_cause_nxt = trap_cause;
      trap_pc_nxt    = trap_pc;
      case (state)
         ST_EMPTY: begin
            if (drop) begin
               if (dmem_rsp_valid) begin
                  drop_nxt = 1'b0;
               end
            end else if (accept) begin
               if (s4_trap) begin
                  trap_valid_nxt = 1'b1;
                  trap_cause_nxt = s4_opr_a[5:0];
                  trap_pc_nxt    = s4_pc;
               end else if (!s4_fu[2]) begin
                  wb_valid_nxt = 1'b1;
                  wb_wen_nxt   = (s4_rd != 5'd0);
                  wb_rd_nxt    = s4_rd;
                  wb_wdata_nxt = s4_opr_a;
                  wb_pc_nxt    = s4_pc;
               end else begin
                  mem_rd_nxt  = s4_rd;
                  mem_pc_nxt  = s4_pc;
                  mem_uop_nxt = s4_uop;
                  mem_off_nxt = s4_opr_b[1:0];
                  state_nxt   = ST_MEM_WAIT;
               end
            end
         end
         ST_MEM_WAIT: begin
            if (dmem_rsp_valid) begin
               state_nxt = ST_EMPTY;
               if (!flush) begin
                  if (dmem_rsp_error) begin
                     trap_valid_nxt = 1'b1;
                     trap_cause_nxt = mem_uop[4] ? 6'd7 : 6'd5;
                     trap_pc_nxt    = mem_pc;
                  end else begin
                     wb_valid_nxt = 1'b1;
                     wb_rd_nxt    = mem_rd;
                     wb_pc_nxt    = mem_pc;
                     if (!mem_uop[4]) begin
                        wb_wen_nxt   = (mem_rd != 5'd0);
                        wb_wdata_nxt = load_data;
                     end
                  end
               end
            end else if (flush) begin
               // Response still owed by memory; swallow it when it comes.
               state_nxt = ST_EMPTY;
               drop_nxt  = 1'b1;
            end
         end
         default: state_nxt = ST_EMPTY;
      endcase
   end

   // Output process
   always_comb begin
      s4_p_busy = (state == ST_MEM_WAIT) || drop;
   end

endmodule

`default_nettype wire

// File: doc/frv_pipeline_memory.md
Name: frv_pipeline_memory

Overview:
- Stage 4 of the core pipeline. Sits directly downstream of the execute stage and consumes its s4_* pipeline outputs.
- Retires ALU/MUL/CSR/CFU results. For loads and stores issued by execute, it waits for the data-memory response, then aligns and extends load data. Bus errors and upstream traps become trap events.
- Drives the registered writeback port into the GPR file. That port also serves as the forwarding source.

Parameters:
- XLEN, 32, data path width; XL = XLEN-1.

Ports:
- g_clk  in  1  global clock
- g_resetn  in  1  asynchronous active-low reset
- s4_rd  in  5  destination register
- s4_opr_a  in  XLEN  execute result; trap cause in [5:0] when s4_trap=1
- s4_opr_b  in  XLEN  memory address of a load/store
- s4_pc  in  32  instruction PC
- s4_uop  in  5  micro-op
- s4_fu  in  5  one-hot functional unit; bit 2 = LSU
- s4_trap  in  1  execute raised a trap
- s4_p_valid  in  1  s4 inputs valid
- s4_p_busy  out  1  stage cannot accept
- flush  in  1  kill in-flight instruction
- dmem_rsp_valid  in  1  memory response strobe
- dmem_rsp_error  in  1  bus error with response
- dmem_rsp_rdata  in  32  raw word read data
- wb_valid  out  1  one-cycle retire pulse
- wb_wen  out  1  GPR write enable
- wb_rd  out  5  GPR address
- wb_wdata  out  XLEN  GPR write data
- wb_pc  out  32  PC of retiring instruction
- trap_valid  out  1  one-cycle trap pulse
- trap_cause  out  6  trap cause
- trap_pc  out  32  trap PC

Behaviour:
- Reset (asynchronous, g_resetn=0): state EMPTY, drop flag clear; all outputs 0; s4_p_busy=0.
- LSU uop encoding:
  - [0] signed
  - [2:1] width: 00 byte, 01 half, 10 word
  - [3] load
  - [4] store
- Accept when s4_p_valid && !s4_p_busy && !flush.
- s4_p_busy = (state==MEM_WAIT) || drop. Combinational from registers only; there is no overlap between a pending memory op and a new accept.
- States: EMPTY, MEM_WAIT.
- Non-LSU accept, or any accept with s4_trap=1, at edge N:
  - Registered outputs are valid in cycle N+1; state stays EMPTY.
  - With s4_trap=1: trap_valid=1, trap_cause=s4_opr_a[5:0], trap_pc=s4_pc, wb_valid=0, wb_wen=0.
  - Otherwise: wb_valid=1, wb_wen=(s4_rd!=0), wb_rd=s4_rd, wb_wdata=s4_opr_a, wb_pc=s4_pc.
- LSU load/store accept: latch rd, pc, uop and addr[1:0]; state goes to MEM_WAIT.
- In MEM_WAIT, on the edge sampling dmem_rsp_valid=1, state returns to EMPTY and outputs are valid in the following cycle:
  - Error: trap_valid=1, trap_cause=5 (load) or 7 (store), trap_pc=pc, wb_wen=0.
  - Store OK: wb_valid=1, wb_wen=0.
  - Load OK: wb_valid=1, wb_wen=(rd!=0), wb_wdata=formatted data.
- Load formatting, with off = addr[1:0]:
  - byte: rdata[8*off+7:8*off].
  - half: rdata[16*off[1]+15:16*off[1]]; off[0] is ignored because misalignment is trapped upstream.
  - word: rdata unchanged.
  - Signed ops sign-extend the MSB of the selected field; unsigned ops zero-extend.
- Pulses: wb_valid and trap_valid are high for exactly one cycle. wb_wen is 0 whenever wb_valid=0. Other wb_*/trap_* fields hold their last value.
- flush:
  - Blocks accept that cycle and suppresses any retire/trap that would register at that edge.
  - In MEM_WAIT with dmem_rsp_valid=0: state goes to EMPTY and drop is set. The next dmem_rsp_valid clears drop, its data is discarded, and no wb/trap pulse is produced.
  - In MEM_WAIT with dmem_rsp_valid=1 in the same cycle: the response is discarded and drop stays clear.
- dmem_rsp_valid while EMPTY and drop=0 is ignored.
- Latency: non-memory ops take 1 cycle from accept to retire. Memory ops retire 1 cycle after the response edge.

Test Plan:
1. ALU retire: accept rd=3, opr_a=0x1234 -> next cycle wb_valid=1, wb_wen=1, wb_rd=3, wb_wdata=0x1234; wb_valid=0 the cycle after.
2. Load byte signed: addr=0x...02, rdata=0x00800000 -> 1 cycle after the response, wb_wdata=0xFFFFFF80. Same access as unsigned -> 0x00000080. s4_p_busy=1 throughout MEM_WAIT.
3. Load half unsigned: addr off=2, rdata=0xBEEF1234 -> wb_wdata=0x0000BEEF. With rd=0 -> wb_valid=1, wb_wen=0.
4. Store with dmem_rsp_error=1 at pc=0x80 -> trap_valid pulse, trap_cause=7, trap_pc=0x80, wb_valid=0. Upstream s4_trap with opr_a=2 -> trap_cause=2.
5. Flush during MEM_WAIT before the response -> busy stays 1 until the stale response arrives; no wb/trap pulse; the next ALU op is accepted the following cycle and retires normally.
6. Assert g_resetn=0 asynchronously mid-MEM_WAIT -> all outputs 0 immediately; a late response after reset is ignored.
